zone_stat_engine: RTL and testbench

//  Parametrised successor to the per-zone gray statistics block for the MiniLED backlight.
//  - Accumulates per-pixel max-channel values over a ZONES_X x ZONES_Y grid of square zones.
//  - Scales each zone statistic by a brightness gain.
//  - Streams one duty word per zone to the LED-board driver over a valid/ready handshake.
//  - Sits between the video timing/pixel path and the LED-board serializer.

---
 rtl/zone_stat_engine.sv | 233 +++++++++++++++++++++++
 tb/tb_zone_stat_engine.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/zone_stat_engine.sv
// zone_stat_engine: per-zone max-channel statistics, gain scaling and duty streaming to the LED board.
// Build option ZONE_PEAK_EN adds per-zone peak capture selectable through mode.
`timescale 1ns/1ps
module zone_stat_engine #(
    parameter int ZONES_X   = 24,
    parameter int ZONES_Y   = 15,
    parameter int ZONE_W    = 46,
    parameter int PITCH     = 53,
    parameter int ORIGIN    = 4,
    parameter int PIX_W     = 8,
    parameter int ACC_W     = 19,
    parameter int AVG_SHIFT = 3,
    parameter int OUT_W     = 16
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             new_frame,
    input  logic             pix_valid,
    input  logic [10:0]      row_cnt,
    input  logic [10:0]      column_cnt,
    input  logic [PIX_W-1:0] pix_max,
    input  logic [15:0]      gain,
    input  logic             mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [8:0]       out_index,
    output logic [OUT_W-1:0] out_data,
    output logic             frame_done,
    output logic             err_overrun
);
    localparam int CW  = (ZONES_X > 1) ? $clog2(ZONES_X) : 1;
    localparam int RW  = $clog2(ZONES_Y + 1);
    localparam int AW1 = ACC_W + 1;
    localparam logic [CW-1:0]    LAST_COL = CW'(ZONES_X - 1);
    localparam logic [RW-1:0]    ROW_STOP = RW'(ZONES_Y);
    localparam logic [8:0]       LAST_IDX = 9'(ZONES_X * ZONES_Y - 1);
    localparam logic [ACC_W-1:0] ACC_MAX  = '1;
    localparam logic [15:0]      OUT_MAX  = 16'((32'd1 << OUT_W) - 32'd1);

    // state | meaning
    // IDLE  | no snapshot pending drain
    // CALC  | computing duty of drain_col
    // HOLD  | word presented, waiting for out_ready
    typedef enum logic [1:0] {IDLE, CALC, HOLD} state_t;

    state_t           state;
    logic [ACC_W-1:0] acc    [ZONES_X];
    logic [ACC_W-1:0] shadow [ZONES_X];
    logic [10:0]      col_start, row_start;
    logic [CW-1:0]    col_idx, drain_col;
    logic [RW-1:0]    zone_row, snap_row;
    logic             snap_pend;

    logic             pix_ok, col_last, in_win, zone_last;
    logic [11:0]      col_end, row_end;
    logic [ACC_W-1:0] mean_full;
    logic [15:0]      stat, peak_stat;
    logic             use_peak;
    logic [31:0]      prod;
    logic [15:0]      duty;

    assign pix_ok    = pix_valid && !new_frame;
    assign col_end   = {1'b0, col_start} + 12'(ZONE_W - 1);
    assign row_end   = {1'b0, row_start} + 12'(ZONE_W - 1);
    assign col_last  = pix_ok && ({1'b0, column_cnt} == col_end);
    assign in_win    = pix_ok && (zone_row != ROW_STOP)
                     && (row_cnt >= row_start) && ({1'b0, row_cnt} <= row_end)
                     && (column_cnt >= col_start) && ({1'b0, column_cnt} <= col_end);
    assign zone_last = in_win && (col_idx == LAST_COL)
                     && ({1'b0, row_cnt} == row_end) && ({1'b0, column_cnt} == col_end);

    function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] a, input logic [PIX_W-1:0] p);
        logic [ACC_W:0] s;
        s = {1'b0, a} + AW1'(p);
        return s[ACC_W] ? ACC_MAX : s[ACC_W-1:0];
    endfunction

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            col_start <= 11'(ORIGIN);
            row_start <= 11'(ORIGIN);
            col_idx   <= '0;
            zone_row  <= '0;
            snap_row  <= '0;
            snap_pend <= 1'b0;
            for (int i = 0; i < ZONES_X; i++) begin
                acc[i]    <= '0;
                shadow[i] <= '0;
            end
        end else if (new_frame) begin
            col_start <= 11'(ORIGIN);
            row_start <= 11'(ORIGIN);
            col_idx   <= '0;
            zone_row  <= '0;
            snap_row  <= '0;
            snap_pend <= 1'b0;
            for (int i = 0; i < ZONES_X; i++) begin
                acc[i]    <= '0;
                shadow[i] <= '0;
            end
        end else begin
            snap_pend <= zone_last;
            if (col_last) begin
                if (col_idx == LAST_COL) begin
                    col_idx   <= '0;
                    col_start <= 11'(ORIGIN);
                end else begin
                    col_idx   <= col_idx + 1'b1;
                    col_start <= col_start + 11'(PITCH);
                end
            end
            if (zone_last) begin
                zone_row  <= zone_row + 1'b1;
                row_start <= row_start + 11'(PITCH);
            end
            // zone_row has already advanced when the snapshot lands
            if (snap_pend)
                snap_row <= zone_row - 1'b1;
            for (int i = 0; i < ZONES_X; i++) begin
                if (snap_pend) begin
                    shadow[i] <= acc[i];
                    acc[i]    <= (in_win && col_idx == CW'(i)) ? ACC_W'(pix_max) : '0;
                end else if (in_win && col_idx == CW'(i)) begin
                    acc[i] <= sat_add(acc[i], pix_max);
                end
            end
        end
    end

`ifdef ZONE_PEAK_EN
    logic [PIX_W-1:0] peak_acc [ZONES_X];
    logic [PIX_W-1:0] peak_sh  [ZONES_X];
    logic             mode_q;

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            mode_q <= 1'b0;
            for (int i = 0; i < ZONES_X; i++) begin
                peak_acc[i] <= '0;
                peak_sh[i]  <= '0;
            end
        end else if (new_frame) begin
            mode_q <= 1'b0;
            for (int i = 0; i < ZONES_X; i++) begin
                peak_acc[i] <= '0;
                peak_sh[i]  <= '0;
            end
        end else begin
            if (snap_pend)
                mode_q <= mode;
            for (int i = 0; i < ZONES_X; i++) begin
                if (snap_pend) begin
                    peak_sh[i]  <= peak_acc[i];
                    peak_acc[i] <= (in_win && col_idx == CW'(i)) ? pix_max : '0;
                end else if (in_win && col_idx == CW'(i) && pix_max > peak_acc[i]) begin
                    peak_acc[i] <= pix_max;
                end
            end
        end
    end

    assign peak_stat = 16'(peak_sh[drain_col]) << (16 - PIX_W);
    assign use_peak  = mode_q;
`else
    logic unused_mode;
    assign unused_mode = mode;
    assign peak_stat   = '0;
    assign use_peak    = 1'b0;
`endif

    always_comb begin
        mean_full = shadow[drain_col] >> AVG_SHIFT;
        stat      = (32'(mean_full) > 32'hFFFF) ? 16'hFFFF : 16'(mean_full);
        if (use_peak)
            stat = peak_stat;
        prod = stat * gain;
        duty = (prod[31:16] > OUT_MAX) ? OUT_MAX : prod[31:16];
    end

    logic unused_prod;
    assign unused_prod = ^prod[15:0];

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            state       <= IDLE;
            drain_col   <= '0;
            out_valid   <= 1'b0;
            out_index   <= '0;
            out_data    <= '0;
            frame_done  <= 1'b0;
            err_overrun <= 1'b0;
        end else if (new_frame) begin
            state       <= IDLE;
            drain_col   <= '0;
            out_valid   <= 1'b0;
            out_index   <= '0;
            out_data    <= '0;
            frame_done  <= 1'b0;
            err_overrun <= 1'b0;
        end else begin
            frame_done <= out_valid && out_ready && (out_index == LAST_IDX);
            if (snap_pend) begin
                // a fresh snapshot always wins; unsent words of the old row are lost
                if (state != IDLE)
                    err_overrun <= 1'b1;
                state     <= CALC;
                drain_col <= '0;
                out_valid <= 1'b0;
            end else begin
                case (state)
                    CALC: begin
                        out_data  <= OUT_W'(duty);
                        out_index <= 9'(snap_row * ZONES_X) + 9'(drain_col);
                        out_valid <= 1'b1;
                        state     <= HOLD;
                    end
                    HOLD: begin
                        if (out_ready) begin
                            out_valid <= 1'b0;
                            if (drain_col == LAST_COL) begin
                                state <= IDLE;
                            end else begin
                                drain_col <= drain_col + 1'b1;
                                state     <= CALC;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_zone_stat_engine.sv
// Randomized bench for zone_stat_engine on a reduced zone grid, checked against an arithmetic zone model.
`timescale 1ns/1ps
module tb_zone_stat_engine;
    localparam int ZX = 4, ZY = 3, ZW = 3, PT = 5, OG = 2;
    localparam int PW = 8, AW = 12, SH = 1, OW = 16;
    localparam int FW = 22, FH = 21;
    localparam int LAST = ZX * ZY - 1;
    localparam int OUT_MAX = (1 << OW) - 1;
`ifdef ZONE_PEAK_EN
    localparam bit PEAK_BUILD = 1'b1;
`else
    localparam bit PEAK_BUILD = 1'b0;
`endif

    logic          sys_clk = 1'b0, sys_rst = 1'b0;
    logic          new_frame = 1'b0, pix_valid = 1'b0, mode = 1'b0, out_ready = 1'b0;
    logic [10:0]   row_cnt = '0, column_cnt = '0;
    logic [PW-1:0] pix_max = '0;
    logic [15:0]   gain = '0;
    logic          out_valid, frame_done, err_overrun;
    logic [8:0]    out_index;
    logic [OW-1:0] out_data;

    zone_stat_engine #(.ZONES_X(ZX), .ZONES_Y(ZY), .ZONE_W(ZW), .PITCH(PT), .ORIGIN(OG),
                       .PIX_W(PW), .ACC_W(AW), .AVG_SHIFT(SH), .OUT_W(OW)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .new_frame(new_frame), .pix_valid(pix_valid),
        .row_cnt(row_cnt), .column_cnt(column_cnt), .pix_max(pix_max), .gain(gain), .mode(mode),
        .out_valid(out_valid), .out_ready(out_ready), .out_index(out_index), .out_data(out_data),
        .frame_done(frame_done), .err_overrun(err_overrun));

    always #5 sys_clk = ~sys_clk;

    int n_checks = 0, n_errors = 0;
    int exp_idx_q[$], exp_dat_q[$];
    int pix_arr[FH][FW];
    int fd_count = 0;
    bit stab_en = 1'b1;
    int ready_mode = 0;
    int hold_idx = -1, hold_left = 0;

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int zone_of(input int p, input int n);
        if (p < OG) return -1;
        if ((p - OG) % PT >= ZW) return -1;
        if ((p - OG) / PT >= n) return -1;
        return (p - OG) / PT;
    endfunction

    function automatic int duty_of(input int sum, input int pk, input int g, input bit md);
        int     stat;
        longint p;
        stat = sum >> SH;
        if (stat > 65535) stat = 65535;
        if (md && PEAK_BUILD) stat = pk << (16 - PW);
        p = (longint'(stat) * longint'(g)) >> 16;
        if (p > OUT_MAX) p = OUT_MAX;
        return int'(p);
    endfunction

    task automatic build_expected(input int g, input bit md, input int first_row);
        int sums[ZY][ZX];
        int pks[ZY][ZX];
        int zr, zc;
        for (int r = 0; r < ZY; r++)
            for (int c = 0; c < ZX; c++) begin
                sums[r][c] = 0;
                pks[r][c]  = 0;
            end
        for (int r = 0; r < FH; r++)
            for (int c = 0; c < FW; c++) begin
                zr = zone_of(r, ZY);
                zc = zone_of(c, ZX);
                if (zr >= 0 && zc >= 0) begin
                    sums[zr][zc] += pix_arr[r][c];
                    if (sums[zr][zc] > (1 << AW) - 1) sums[zr][zc] = (1 << AW) - 1;
                    if (pix_arr[r][c] > pks[zr][zc]) pks[zr][zc] = pix_arr[r][c];
                end
            end
        for (int r = first_row; r < ZY; r++)
            for (int c = 0; c < ZX; c++) begin
                exp_idx_q.push_back(r * ZX + c);
                exp_dat_q.push_back(duty_of(sums[r][c], pks[r][c], g, md));
            end
    endtask

    // patterns: 0 flat 0x80, 1 random, 2 single 0xFF in zone 7, 3 all 0xFF
    task automatic fill_pixels(input int pat);
        for (int r = 0; r < FH; r++)
            for (int c = 0; c < FW; c++)
                case (pat)
                    0:       pix_arr[r][c] = 8'h80;
                    1:       pix_arr[r][c] = int'($urandom_range(0, 255));
                    2:       pix_arr[r][c] = (r == OG + PT + 1 && c == OG + 3 * PT + 1) ? 8'hFF : 0;
                    default: pix_arr[r][c] = 8'hFF;
                endcase
    endtask

    task automatic pulse_new_frame();
        @(posedge sys_clk); #1;
        new_frame = 1'b1; pix_valid = 1'b1;
        row_cnt = 11'(OG); column_cnt = 11'(OG); pix_max = 8'hFF;
        @(posedge sys_clk); #1;
        new_frame = 1'b0; pix_valid = 1'b0;
    endtask

    task automatic drive_frame(input int last_row, input int ready_row);
        for (int r = 0; r <= last_row; r++)
            for (int c = 0; c < FW; c++) begin
                if ($urandom_range(0, 4) == 0) begin
                    @(posedge sys_clk); #1;
                    pix_valid = 1'b0;
                    row_cnt = 11'($urandom_range(0, 2047));
                    column_cnt = 11'($urandom_range(0, 2047));
                    pix_max = 8'($urandom_range(0, 255));
                end
                @(posedge sys_clk); #1;
                if (r == ready_row && c == 0) ready_mode = 0;
                pix_valid = 1'b1;
                row_cnt = 11'(r); column_cnt = 11'(c); pix_max = 8'(pix_arr[r][c]);
            end
        @(posedge sys_clk); #1;
        pix_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int t = 0;
        while (exp_idx_q.size() > 0 && t < 3000) begin
            @(posedge sys_clk);
            t++;
        end
        chk("drain_left", exp_idx_q.size(), 0);
        repeat (4) @(posedge sys_clk);
    endtask

    task automatic run_frame(input int g, input bit md, input int pat, input bit ovr);
        @(posedge sys_clk); #1;
        gain = 16'(g); mode = md;
        fill_pixels(pat);
        build_expected(g, md, ovr ? 1 : 0);
        stab_en = !ovr;
        ready_mode = ovr ? 1 : 0;
        pulse_new_frame();
        fd_count = 0;
        drive_frame(FH - 1, ovr ? OG + 2 * PT - 2 : -1);
        wait_drain();
        chk("frame_done_count", fd_count, 1);
        chk("err_overrun", err_overrun, longint'(ovr));
        chk("idle_valid", out_valid, 0);
        stab_en = 1'b1;
    endtask

    task automatic new_frame_mid_drain();
        int t = 0;
        @(posedge sys_clk); #1;
        gain = 16'($urandom_range(1, 65535)); mode = 1'b0;
        fill_pixels(1);
        build_expected(int'(gain), 1'b0, 0);
        ready_mode = 0; hold_idx = 5; hold_left = 100000;
        pulse_new_frame();
        fd_count = 0;
        drive_frame(OG + PT + ZW - 1, -1);
        while (!(out_valid && out_index == 9'd5) && t < 500) begin
            @(negedge sys_clk);
            t++;
        end
        chk("reach_idx5", out_index, 5);
        stab_en = 1'b0;
        @(posedge sys_clk); #1;
        new_frame = 1'b1;
        @(posedge sys_clk); #1;
        new_frame = 1'b0;
        @(negedge sys_clk);
        chk("nf_out_valid", out_valid, 0);
        chk("nf_err", err_overrun, 0);
        chk("nf_frame_done", fd_count, 0);
        hold_left = 0; hold_idx = -1;
        exp_idx_q.delete(); exp_dat_q.delete();
        stab_en = 1'b1;
    endtask

    initial begin
        forever begin
            @(posedge sys_clk); #1;
            if (out_valid && int'(out_index) == hold_idx && hold_left > 0) begin
                out_ready = 1'b0;
                hold_left--;
            end else if (ready_mode == 1) begin
                out_ready = 1'b0;
            end else begin
                out_ready = ($urandom_range(0, 3) != 0);
            end
        end
    end

    logic [8:0]    prev_idx = '0;
    logic [OW-1:0] prev_dat = '0;
    bit prev_hold = 1'b0, prev_acc = 1'b0, prev_last = 1'b0;
    initial begin
        forever begin
            @(negedge sys_clk);
            if (sys_rst) begin
                if (stab_en && prev_hold) begin
                    chk("hold_valid", out_valid, 1);
                    chk("hold_index", out_index, prev_idx);
                    chk("hold_data", out_data, prev_dat);
                end
                if (prev_acc || frame_done) chk("frame_done", frame_done, prev_last);
                if (frame_done) fd_count++;
                prev_hold = out_valid && !out_ready;
                prev_idx  = out_index;
                prev_dat  = out_data;
                prev_acc  = out_valid && out_ready;
                prev_last = prev_acc && (out_index == 9'(LAST));
                if (out_valid && out_ready) begin
                    chk("word_expected", exp_idx_q.size() > 0, 1);
                    if (exp_idx_q.size() > 0) begin
                        chk("out_index", out_index, exp_idx_q.pop_front());
                        chk("out_data", out_data, exp_dat_q.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(posedge sys_clk);
        #1 sys_rst = 1'b1;
        @(negedge sys_clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_index", out_index, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_err_overrun", err_overrun, 0);

        run_frame(16'hFFFF, 1'b0, 0, 1'b0);
        run_frame(16'h8000, 1'b0, 0, 1'b0);
        run_frame(0, 1'b0, 0, 1'b0);
        hold_idx = 5; hold_left = 10;
        run_frame(int'($urandom_range(0, 65535)), 1'b0, 1, 1'b0);
        hold_idx = -1; hold_left = 0;
        run_frame(int'($urandom_range(0, 65535)), 1'b1, 1, 1'b0);
        run_frame(int'($urandom_range(0, 65535)), 1'($urandom_range(0, 1)), 1, 1'b0);
        run_frame(16'hFFFF, 1'b1, 2, 1'b0);
        run_frame(16'hFFFF, 1'b0, 3, 1'b0);
        run_frame(16'hFFFF, 1'b1, 3, 1'b0);
        run_frame(int'($urandom_range(0, 65535)), 1'b0, 1, 1'b1);
        new_frame_mid_drain();
        run_frame(int'($urandom_range(0, 65535)), 1'b0, 1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
